skolem_exhaustive_checker: RTL and testbench

- Sequential verifier for parametrised parity (XOR-system) Skolem candidates of the kind synthesized for the xor_N_M benchmarks.
- Enumerates all 2^NUM_X input assignments and drives each one to an external combinational or pipelined candidate netlist.
- Samples the candidate's Y outputs and evaluates the parity specification for each assignment.
- Reports pass, or the first counterexample. Sits in the bench/FPGA harness next to generated SKOLEMFORMULA netlists.

---
 rtl/skolem_exhaustive_checker.sv | 186 ++++++++++++++++++
 tb/tb_skolem_exhaustive_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_exhaustive_checker.sv
// ---------------------------------------------------------------------------
// skolem_exhaustive_checker
//
// Exhaustive verifier for parity (XOR-system) Skolem candidates. Walks every
// X assignment from 0 up to all-ones, drives it to an external candidate
// netlist (combinational or pipelined), samples the candidate's Y outputs and
// checks every parity constraint. Reports pass or the first counterexample.
//
// Constraint k holds when
//   ^(x & XMASK[k*NUM_X +: NUM_X]) ^ ^(y & YMASK[k*NUM_Y +: NUM_Y]) == RHS[k]
//
// Optional feature (macro SKOLEM_CHECK_FULL_SCAN_EN):
//   defined   - a failure does not stop the scan, every assignment is checked,
//               cex_* hold the first failure, fail_cnt counts failures and
//               pass = (fail_cnt == 0).
//   undefined - the scan stops at the first failure; no fail_cnt port.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start      in   begin a scan; honoured in IDLE and DONE only
//   cand_x     out  [NUM_X-1:0] assignment driven to the candidate
//   cand_y     in   [NUM_Y-1:0] candidate outputs
//   busy       out  scan in progress
//   done       out  scan finished; held until the next accepted start
//   pass       out  all checked assignments satisfied (valid when done=1)
//   cex_valid  out  counterexample captured
//   cex_x      out  [NUM_X-1:0] failing assignment
//   cex_y      out  [NUM_Y-1:0] candidate outputs at cex_x
//   chk_cnt    out  [NUM_X:0]   number of assignments checked
//   dbg_state  out  [1:0]       current FSM state (IDLE=0, EVAL=1, DONE=2)
//   fail_cnt   out  [NUM_X:0]   failing assignments (full-scan build only)
// ---------------------------------------------------------------------------
module skolem_exhaustive_checker #(
    parameter int                       NUM_X    = 5,
    parameter int                       NUM_Y    = 3,
    parameter logic [NUM_Y*NUM_X-1:0]   XMASK    = 15'b10110_01101_10011,
    parameter logic [NUM_Y*NUM_Y-1:0]   YMASK    = 9'b111_011_001,
    parameter logic [NUM_Y-1:0]         RHS      = '0,
    parameter int                       CAND_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [NUM_X-1:0] cand_x,
    input  logic [NUM_Y-1:0] cand_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             cex_valid,
    output logic [NUM_X-1:0] cex_x,
    output logic [NUM_Y-1:0] cex_y,
    output logic [NUM_X:0]   chk_cnt,
    output logic [1:0]       dbg_state
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    ,
    output logic [NUM_X:0]   fail_cnt
`endif
);

    // Wait counter sized for CAND_LAT; at least one bit so CAND_LAT=0 works.
    localparam int              WW    = (CAND_LAT > 0) ? $clog2(CAND_LAT + 1) : 1;
    localparam logic [WW-1:0]   WLAST = WW'(CAND_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WW-1:0]     wcnt;
    logic [NUM_Y-1:0]  sat;
    logic              ok;
    logic              accept;   // start honoured this cycle
    logic              check;    // final settle cycle of the current assignment
    logic              finish;   // this check ends the scan
    logic              last_x;

    // Parity evaluation of every constraint against the live candidate outputs.
    always_comb begin
        sat = '0;
        for (int k = 0; k < NUM_Y; k++) begin
            sat[k] = (^(cand_x & XMASK[k*NUM_X +: NUM_X]))
                   ^ (^(cand_y & YMASK[k*NUM_Y +: NUM_Y]))
                   ^ ~RHS[k];
        end
        ok = &sat;
    end

    assign last_x = &cand_x;

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        check      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (wcnt == WLAST) begin
                    check = 1'b1;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
                    finish = last_x;
`else
                    finish = last_x || !ok;
`endif
                    if (finish) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand_x    <= '0;
            wcnt      <= '0;
            chk_cnt   <= '0;
            pass      <= 1'b0;
            cex_valid <= 1'b0;
            cex_x     <= '0;
            cex_y     <= '0;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
            fail_cnt  <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                cand_x    <= '0;
                wcnt      <= '0;
                chk_cnt   <= '0;
                pass      <= 1'b0;
                cex_valid <= 1'b0;
                cex_x     <= '0;
                cex_y     <= '0;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
                fail_cnt  <= '0;
`endif
            end else if (state == EVAL) begin
                if (!check) begin
                    wcnt <= wcnt + 1'b1;
                end else begin
                    wcnt    <= '0;
                    chk_cnt <= chk_cnt + 1'b1;
                    // Only the first failure is recorded.
                    if (!ok && !cex_valid) begin
                        cex_valid <= 1'b1;
                        cex_x     <= cand_x;
                        cex_y     <= cand_y;
                    end
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
                    if (!ok) begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                    if (finish) begin
                        pass <= (fail_cnt == '0) && ok;
                    end
`else
                    if (finish) begin
                        pass <= ok;
                    end
`endif
                    // cand_x holds its last value once the scan ends.
                    if (!finish) begin
                        cand_x <= cand_x + 1'b1;
                    end
                end
            end
        end
    end

    assign busy      = (state == EVAL);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// ---------------------------------------------------------------------------
// Bench for skolem_exhaustive_checker. Two instances share one parameter set:
// dut0 with a combinational candidate (CAND_LAT=0) and dut1 with a two-stage
// registered candidate (CAND_LAT=2). The candidate solves the triangular
// parity system exactly; a fault table flips chosen Y bits at chosen X values.
// Expected results come from evaluating the parity rules over all 32
// assignments with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_skolem_exhaustive_checker;

  localparam int NX = 5;
  localparam int NY = 3;
  localparam logic [NY*NX-1:0] XM = 15'b10110_01101_10011;
  localparam logic [NY*NY-1:0] YM = 9'b111_011_001;
  localparam logic [NY-1:0]    RH = 3'b101;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, start0, start1;
  logic [NX-1:0] cand_x0, cand_x1, cex_x0, cex_x1;
  logic [NY-1:0] cand_y0, cand_y1, cex_y0, cex_y1, pipe1;
  logic busy0, busy1, done0, done1, pass0, pass1, cexv0, cexv1;
  logic [NX:0] chk0, chk1;
  logic [1:0] dbg0, dbg1;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
  logic [NX:0] fcnt0, fcnt1;
`endif

  logic [NY-1:0] flip_tab [32];
  int n_cmp = 0;
  int n_bad = 0;
  bit sel = 1'b0;

  skolem_exhaustive_checker #(.NUM_X(NX), .NUM_Y(NY), .XMASK(XM), .YMASK(YM),
                              .RHS(RH), .CAND_LAT(0)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .cand_x(cand_x0), .cand_y(cand_y0),
    .busy(busy0), .done(done0), .pass(pass0), .cex_valid(cexv0),
    .cex_x(cex_x0), .cex_y(cex_y0), .chk_cnt(chk0), .dbg_state(dbg0)
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    , .fail_cnt(fcnt0)
`endif
  );

  skolem_exhaustive_checker #(.NUM_X(NX), .NUM_Y(NY), .XMASK(XM), .YMASK(YM),
                              .RHS(RH), .CAND_LAT(2)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .cand_x(cand_x1), .cand_y(cand_y1),
    .busy(busy1), .done(done1), .pass(pass1), .cex_valid(cexv1),
    .cex_x(cex_x1), .cex_y(cex_y1), .chk_cnt(chk1), .dbg_state(dbg1)
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
    , .fail_cnt(fcnt1)
`endif
  );

  // candidate solution by forward substitution of the triangular system
  function automatic logic [NY-1:0] good_y(input logic [NX-1:0] x);
    logic [NY-1:0] y;
    logic [NY-1:0] others;
    int p;
    y = '0;
    for (int k = 0; k < NY; k++) begin
      others = YM[k*NY +: NY];
      others[k] = 1'b0;
      p = $countones(x & XM[k*NX +: NX]) + $countones(y & others) + int'(RH[k]);
      y[k] = (p % 2) == 1;
    end
    return y;
  endfunction

  // all parity constraints satisfied?
  function automatic bit spec_ok(input logic [NX-1:0] x, input logic [NY-1:0] y);
    int p;
    for (int k = 0; k < NY; k++) begin
      p = $countones(x & XM[k*NX +: NX]) + $countones(y & YM[k*NY +: NY]);
      if ((p % 2) != int'(RH[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always_comb cand_y0 = good_y(cand_x0) ^ flip_tab[cand_x0];

  always_ff @(posedge clk) begin
    pipe1   <= good_y(cand_x1) ^ flip_tab[cand_x1];
    cand_y1 <= pipe1;
  end

  // observed-instance mux
  logic busy_s, done_s, pass_s, cexv_s;
  logic [NX-1:0] cand_x_s, cex_x_s;
  logic [NY-1:0] cex_y_s;
  logic [NX:0] chk_s, fcnt_s;
  assign busy_s   = sel ? busy1   : busy0;
  assign done_s   = sel ? done1   : done0;
  assign pass_s   = sel ? pass1   : pass0;
  assign cexv_s   = sel ? cexv1   : cexv0;
  assign cand_x_s = sel ? cand_x1 : cand_x0;
  assign cex_x_s  = sel ? cex_x1  : cex_x0;
  assign cex_y_s  = sel ? cex_y1  : cex_y0;
  assign chk_s    = sel ? chk1    : chk0;
`ifdef SKOLEM_CHECK_FULL_SCAN_EN
  assign fcnt_s   = sel ? fcnt1   : fcnt0;
`else
  assign fcnt_s   = '0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic check_idle(input string name);
    check_eq({name, ".busy"},   32'(busy_s),   32'd0);
    check_eq({name, ".done"},   32'(done_s),   32'd0);
    check_eq({name, ".pass"},   32'(pass_s),   32'd0);
    check_eq({name, ".cexv"},   32'(cexv_s),   32'd0);
    check_eq({name, ".cand_x"}, 32'(cand_x_s), 32'd0);
    check_eq({name, ".cex_x"},  32'(cex_x_s),  32'd0);
    check_eq({name, ".cex_y"},  32'(cex_y_s),  32'd0);
    check_eq({name, ".chk"},    32'(chk_s),    32'd0);
    if (FULL) check_eq({name, ".fcnt"}, 32'(fcnt_s), 32'd0);
  endtask

  // one scan on the selected instance, optionally poking start mid-scan
  task automatic run_scan(input bit s, input bit poke, input string name);
    int lat, first, nf, checked, done_n, busy_err, n;
    logic [NY-1:0] yv, first_y;
    lat = s ? 2 : 0;
    first = -1; nf = 0; busy_err = 0; first_y = '0;
    for (int x = 0; x < 32; x++) begin
      yv = good_y(NX'(x)) ^ flip_tab[x];
      if (!spec_ok(NX'(x), yv)) begin
        if (first < 0) begin
          first = x;
          first_y = yv;
        end
        nf++;
      end
    end
    checked = (FULL || first < 0) ? 32 : first + 1;
    done_n  = (checked - 1) * (lat + 1) + lat + 2;

    sel = s;
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    check_eq({name, ".x0"},       32'(cand_x_s), 32'd0);
    check_eq({name, ".done_clr"}, 32'(done_s),   32'd0);
    n = 1;
    while (!done_s && n <= 300) begin
      if (busy_s !== (n < done_n)) busy_err++;
      if (poke && done_n > 12) set_start(n == 5 || n == 10);
      @(negedge clk);
      n++;
    end
    set_start(1'b0);
    check_eq({name, ".done_t"},   32'(n),        32'(done_n));
    check_eq({name, ".busy_err"}, 32'(busy_err), 32'd0);
    check_eq({name, ".pass"},     32'(pass_s),   32'(nf == 0));
    check_eq({name, ".cexv"},     32'(cexv_s),   32'(nf > 0));
    check_eq({name, ".cex_x"},    32'(cex_x_s),  (first >= 0) ? 32'(first) : 32'd0);
    check_eq({name, ".cex_y"},    32'(cex_y_s),  32'(first_y));
    check_eq({name, ".chk"},      32'(chk_s),    32'(checked));
    check_eq({name, ".x_last"},   32'(cand_x_s), 32'(checked - 1));
    if (FULL) check_eq({name, ".fcnt"}, 32'(fcnt_s), 32'(nf));
  endtask

  task automatic clear_flips();
    for (int i = 0; i < 32; i++) flip_tab[i] = '0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    clear_flips();
    repeat (3) @(negedge clk);
    sel = 1'b0; check_idle("rst0");
    sel = 1'b1; check_idle("rst1");
    rst0 = 1'b0; rst1 = 1'b0;

    // correct candidate, both latencies, with ignored mid-scan starts
    run_scan(1'b0, 1'b1, "good_l0");
    run_scan(1'b1, 1'b1, "good_l2");

    // y1 inverted only at x=0x13; second scan starts from DONE
    flip_tab[19] = 3'b010;
    run_scan(1'b0, 1'b0, "f13_l0");
    run_scan(1'b0, 1'b0, "f13_again");
    run_scan(1'b1, 1'b1, "f13_l2");

    // failures at x=3 and x=17
    clear_flips();
    flip_tab[3]  = 3'b001;
    flip_tab[17] = 3'b100;
    run_scan(1'b0, 1'b0, "f3_17");

    // reset mid-scan aborts, then a fresh scan completes
    clear_flips();
    sel = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (10) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk); rst0 = 1'b0;
    check_idle("midrst");
    run_scan(1'b0, 1'b0, "after_rst");

    // random fault tables
    for (int r = 0; r < 10; r++) begin
      int nfl;
      clear_flips();
      nfl = $urandom_range(0, 2);
      for (int j = 0; j < nfl; j++)
        flip_tab[$urandom_range(0, 31)] = NY'($urandom_range(1, 7));
      run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
